// File: rtl/jamma_pkg.sv
// Shared definitions for the JAMMA input scanner: bank states, joystick bit map,
// the debounced-input bundle layout and the SOCD cleaning helper.
package jamma_pkg;

  localparam int JOY_UP      = 0;
  localparam int JOY_DOWN    = 1;
  localparam int JOY_LEFT    = 2;
  localparam int JOY_RIGHT   = 3;
  localparam int JOY_FIRE1   = 4;
  localparam int JOY_FIRE2   = 5;
  localparam int JOY_COINBTN = 6;
  localparam int JOY_START   = 7;

  localparam logic [7:0] JOY_RELEASED = 8'hFF;

  localparam int NUM_DB_BITS = 20;

  // Bit 1 of the state is the bank being driven, so jselect decodes cleanly.
  typedef logic [1:0] jamma_state_t;
  localparam jamma_state_t A_SETTLE = 2'b00;
  localparam jamma_state_t A_SAMPLE = 2'b01;
  localparam jamma_state_t B_SETTLE = 2'b10;
  localparam jamma_state_t B_SAMPLE = 2'b11;

  typedef struct packed {
    logic       service_n;
    logic       test_n;
    logic [1:0] coin;
    logic [7:0] joy2;
    logic [7:0] joy1;
  } jamma_inputs_t;

  // Opposing directions held together read as neither (active-low word).
  function automatic logic [7:0] socd_clean(input logic [7:0] j);
    logic [7:0] r;
    r = j;
    if (!j[JOY_UP] && !j[JOY_DOWN]) begin
      r[JOY_UP]   = 1'b1;
      r[JOY_DOWN] = 1'b1;
    end
    if (!j[JOY_LEFT] && !j[JOY_RIGHT]) begin
      r[JOY_LEFT]  = 1'b1;
      r[JOY_RIGHT] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jamma_debounce_bit.sv
// One debounced input bit: the output only moves after DB_SAMPLES consecutive
// sample-point readings that disagree with it.
module jamma_debounce_bit #(
  parameter int DB_SAMPLES = 4
) (
  input  logic pclk,
  input  logic reset,
  input  logic sample,
  input  logic sample_en,
  output logic out
);

  logic       out_q, out_d;
  logic [3:0] cnt_q, cnt_d;

  // The commit happens one cycle after the count is reached, independent of
  // sample_en; the pending value is always the inverse of the current output.
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    if (cnt_q == 4'(DB_SAMPLES)) begin
      out_d = ~out_q;
      cnt_d = '0;
    end else if (sample_en) begin
      if (sample == out_q) cnt_d = '0;
      else                 cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      out_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/jamma_input_scanner.sv
// Scans the shared JAMMA joystick bus bank by bank and debounces every input.
// Optional: define JAMMA_SOCD_CLEAN_EN to cancel opposing directions on joy1/joy2.
module jamma_input_scanner
  import jamma_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int DB_SAMPLES    = 4
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic [7:0] jjoy,
  input  logic [5:0] local_joy,
  input  logic [1:0] jcoin,
  input  logic       jtest,
  input  logic       jservice,
  output logic       jselect,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic [1:0] coin,
  output logic       test_n,
  output logic       service_n,
  output logic       scan_done
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  // Two-flop synchronisers for everything arriving from the cabinet harness.
  logic [11:0] meta_q, sync_q;

  always_ff @(posedge pclk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= {jservice, jtest, jcoin, jjoy};
      sync_q <= meta_q;
    end
  end

  jamma_state_t state_q, state_d;
  logic [7:0]   settle_q, settle_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      A_SETTLE, B_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = (state_q == A_SETTLE) ? A_SAMPLE : B_SAMPLE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      A_SAMPLE: state_d = B_SETTLE;
      B_SAMPLE: state_d = A_SETTLE;
      default:  state_d = A_SETTLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q  <= A_SETTLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  assign jselect   = (state_q == B_SETTLE) || (state_q == B_SAMPLE);
  assign scan_done = (state_q == B_SAMPLE);

  // The bus carries whichever bank is selected, so joy1 and joy2 share it;
  // the sample enables decide which debouncers actually look at it.
  jamma_inputs_t          raw;
  logic [NUM_DB_BITS-1:0] raw_bits, en_bits, db_bits;

  always_comb begin
    raw.joy1      = sync_q[7:0] & {2'b11, local_joy};
    raw.joy2      = sync_q[7:0];
    raw.coin      = sync_q[9:8];
    raw.test_n    = sync_q[10];
    raw.service_n = sync_q[11];
  end

  assign raw_bits = raw;
  assign en_bits  = {{(NUM_DB_BITS-8){state_q == B_SAMPLE}}, {8{state_q == A_SAMPLE}}};

  generate
    for (genvar g = 0; g < NUM_DB_BITS; g++) begin : g_db
      jamma_debounce_bit #(.DB_SAMPLES(DB_SAMPLES)) u_db (
        .pclk      (pclk),
        .reset     (reset),
        .sample    (raw_bits[g]),
        .sample_en (en_bits[g]),
        .out       (db_bits[g])
      );
    end
  endgenerate

  jamma_inputs_t db;
  assign db = db_bits;

`ifdef JAMMA_SOCD_CLEAN_EN
  assign joy1 = socd_clean(db.joy1);
  assign joy2 = socd_clean(db.joy2);
`else
  assign joy1 = db.joy1;
  assign joy2 = db.joy2;
`endif

  assign coin      = db.coin;
  assign test_n    = db.test_n;
  assign service_n = db.service_n;

endmodule
